// File: rtl/snake_body_datapath.sv
`default_nettype none
// ============================================================================
// Module   : snake_body_datapath
// Purpose  : Datapath behind the snake movement controller. Holds the head
//            register, the body position memory and the prev/curr shift
//            registers, turns draw requests into registered pixel writes and
//            reports food / collision status back to the controller.
// Ports    : clk, rst                 - clock, synchronous active-high reset
//            dir                      - requested heading (00 R, 01 L, 10 U, 11 D)
//            ld_head .. inc_length_check - single-cycle controller strobes
//            draw_q, draw_curr, food_en  - draw requests (food > q > curr)
//            cnt_status               - pixel index 0..8 inside the 3x3 cell
//            colour_in                - colour used for draw_q pixels
//            food_x, food_y           - food cell top-left corner
//            x_out, y_out, colour_out, plot - registered pixel write
//            length_inc               - one-cycle pulse, head is on food
//            is_dead                  - sticky wall / self collision flag
// Revision : 1.0 - initial release
// ============================================================================
module snake_body_datapath #(
  parameter int MAX_LEN  = 64,
  parameter int STEP     = 3,
  parameter int SCREEN_W = 160,
  parameter int SCREEN_H = 120,
  parameter int START_X  = 80,
  parameter int START_Y  = 60
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] dir,
  input  logic       ld_head,
  input  logic       ld_q_def,
  input  logic       inc_address,
  input  logic       rst_address,
  input  logic       update_head,
  input  logic       ld_head_into_prev,
  input  logic       ld_q_into_curr,
  input  logic       ld_prev_into_q,
  input  logic       ld_curr_into_prev,
  input  logic       inc_length_check,
  input  logic       draw_q,
  input  logic       draw_curr,
  input  logic       food_en,
  input  logic [3:0] cnt_status,
  input  logic [2:0] colour_in,
  input  logic [7:0] food_x,
  input  logic [6:0] food_y,
  output logic [7:0] x_out,
  output logic [6:0] y_out,
  output logic [2:0] colour_out,
  output logic       plot,
  output logic       length_inc,
  output logic       is_dead
);

  localparam int            AW       = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam logic [AW-1:0] ADDR_MAX = AW'(MAX_LEN - 1);
  localparam logic [1:0]    DIR_RIGHT = 2'b00;
  localparam logic [1:0]    DIR_LEFT  = 2'b01;
  localparam logic [1:0]    DIR_UP    = 2'b10;
  localparam logic [8:0]    X_LIMIT  = 9'(SCREEN_W - STEP);
  localparam logic [7:0]    Y_LIMIT  = 8'(SCREEN_H - STEP);
  localparam logic [8:0]    STEP_X   = 9'(STEP);
  localparam logic [7:0]    STEP_Y   = 8'(STEP);
  localparam logic [7:0]    START_XV = 8'(START_X);
  localparam logic [6:0]    START_YV = 7'(START_Y);
  localparam logic [2:0]    COL_FOOD  = 3'b010;
  localparam logic [2:0]    COL_ERASE = 3'b000;

  // Body memory, no reset: contents are only meaningful once written.
  logic [7:0] mem_x [MAX_LEN];
  logic [6:0] mem_y [MAX_LEN];

  logic [7:0]    head_x_q, head_x_d;
  logic [6:0]    head_y_q, head_y_d;
  logic [7:0]    prev_x_q, prev_x_d;
  logic [6:0]    prev_y_q, prev_y_d;
  logic [7:0]    curr_x_q, curr_x_d;
  logic [6:0]    curr_y_q, curr_y_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [1:0]    heading_q, heading_d;
  logic          hit_q, hit_d;
  logic [7:0]    x_out_q, x_out_d;
  logic [6:0]    y_out_q, y_out_d;
  logic [2:0]    colour_out_q, colour_out_d;
  logic          plot_q, plot_d;
  logic          length_inc_q, length_inc_d;

  // Combinational read of the entry under the address pointer.
  logic [7:0] q_x;
  logic [6:0] q_y;
  assign q_x = mem_x[addr_q];
  assign q_y = mem_y[addr_q];

  // Default body layout: segment n sits n cells to the left of the start.
  logic [8:0] def_x;
  assign def_x = 9'(START_X) - STEP_X * 9'(addr_q);

  // ---------------------------------------------------------------- movement
  logic [1:0] new_heading;
  logic [8:0] cand_x;
  logic [7:0] cand_y;
  logic       wall;

  always_comb begin
    // A request for the exact opposite direction differs only in bit 0.
    new_heading = ((dir ^ 2'b01) == heading_q) ? heading_q : dir;
    cand_x      = {1'b0, head_x_q};
    cand_y      = {1'b0, head_y_q};
    case (new_heading)
      DIR_RIGHT: cand_x = {1'b0, head_x_q} + STEP_X;
      DIR_LEFT:  cand_x = {1'b0, head_x_q} - STEP_X;
      DIR_UP:    cand_y = {1'b0, head_y_q} - STEP_Y;
      default:   cand_y = {1'b0, head_y_q} + STEP_Y;
    endcase
    // Underflow wraps the one-bit-wider sum to a huge value, so the upper
    // bound compare also catches moves off the left/top edge.
    wall = (cand_x > X_LIMIT) || (cand_y > Y_LIMIT);
  end

  // ----------------------------------------------------------------- drawing
  logic [1:0] off_x;
  logic [1:0] off_y;
  logic       cell_ok;
  logic [7:0] base_x;
  logic [6:0] base_y;
  logic [2:0] base_col;

  always_comb begin
    off_x   = 2'd0;
    off_y   = 2'd0;
    cell_ok = 1'b1;
    case (cnt_status)
      4'd0:    begin off_x = 2'd0; off_y = 2'd0; end
      4'd1:    begin off_x = 2'd1; off_y = 2'd0; end
      4'd2:    begin off_x = 2'd2; off_y = 2'd0; end
      4'd3:    begin off_x = 2'd0; off_y = 2'd1; end
      4'd4:    begin off_x = 2'd1; off_y = 2'd1; end
      4'd5:    begin off_x = 2'd2; off_y = 2'd1; end
      4'd6:    begin off_x = 2'd0; off_y = 2'd2; end
      4'd7:    begin off_x = 2'd1; off_y = 2'd2; end
      4'd8:    begin off_x = 2'd2; off_y = 2'd2; end
      default: cell_ok = 1'b0;
    endcase

    base_x   = curr_x_q;
    base_y   = curr_y_q;
    base_col = COL_ERASE;
    if (food_en) begin
      base_x   = food_x;
      base_y   = food_y;
      base_col = COL_FOOD;
    end else if (draw_q) begin
      base_x   = q_x;
      base_y   = q_y;
      base_col = colour_in;
    end
  end

  // -------------------------------------------------------- next-state logic
  always_comb begin
    head_x_d     = head_x_q;
    head_y_d     = head_y_q;
    prev_x_d     = prev_x_q;
    prev_y_d     = prev_y_q;
    curr_x_d     = curr_x_q;
    curr_y_d     = curr_y_q;
    addr_d       = addr_q;
    heading_d    = heading_q;
    hit_d        = hit_q;
    x_out_d      = x_out_q;
    y_out_d      = y_out_q;
    colour_out_d = colour_out_q;

    if (rst_address) begin
      addr_d = '0;
    end else if (inc_address && (addr_q != ADDR_MAX)) begin
      addr_d = addr_q + 1'b1;
    end

    if (update_head) begin
      heading_d = new_heading;
      if (wall) begin
        hit_d = 1'b1;
      end else begin
        head_x_d = cand_x[7:0];
        head_y_d = cand_y[6:0];
      end
    end

    if (ld_head_into_prev) begin
      prev_x_d = head_x_q;
      prev_y_d = head_y_q;
    end
    if (ld_curr_into_prev) begin
      prev_x_d = curr_x_q;
      prev_y_d = curr_y_q;
    end

    if (ld_q_into_curr) begin
      curr_x_d = q_x;
      curr_y_d = q_y;
      // Entry 0 is the head's own slot, so only deeper segments collide.
      if ((addr_q != '0) && (q_x == head_x_q) && (q_y == head_y_q)) begin
        hit_d = 1'b1;
      end
    end

    if (ld_head) begin
      head_x_d  = START_XV;
      head_y_d  = START_YV;
      heading_d = DIR_RIGHT;
      hit_d     = 1'b0;
    end

    length_inc_d = inc_length_check && (head_x_q == food_x) && (head_y_q == food_y);

    plot_d = (food_en || draw_q || draw_curr) && cell_ok;
    if (plot_d) begin
      x_out_d      = base_x + {6'd0, off_x};
      y_out_d      = base_y + {5'd0, off_y};
      colour_out_d = base_col;
    end
  end

  // --------------------------------------------------------------- registers
  always_ff @(posedge clk) begin
    if (rst) begin
      head_x_q     <= START_XV;
      head_y_q     <= START_YV;
      prev_x_q     <= '0;
      prev_y_q     <= '0;
      curr_x_q     <= '0;
      curr_y_q     <= '0;
      addr_q       <= '0;
      heading_q    <= DIR_RIGHT;
      hit_q        <= 1'b0;
      x_out_q      <= '0;
      y_out_q      <= '0;
      colour_out_q <= '0;
      plot_q       <= 1'b0;
      length_inc_q <= 1'b0;
    end else begin
      head_x_q     <= head_x_d;
      head_y_q     <= head_y_d;
      prev_x_q     <= prev_x_d;
      prev_y_q     <= prev_y_d;
      curr_x_q     <= curr_x_d;
      curr_y_q     <= curr_y_d;
      addr_q       <= addr_d;
      heading_q    <= heading_d;
      hit_q        <= hit_d;
      x_out_q      <= x_out_d;
      y_out_q      <= y_out_d;
      colour_out_q <= colour_out_d;
      plot_q       <= plot_d;
      length_inc_q <= length_inc_d;
    end
  end

  // Shifting a segment in takes precedence over loading the default layout.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (ld_prev_into_q) begin
        mem_x[addr_q] <= prev_x_q;
        mem_y[addr_q] <= prev_y_q;
      end else if (ld_q_def) begin
        mem_x[addr_q] <= def_x[7:0];
        mem_y[addr_q] <= START_YV;
      end
    end
  end

  assign x_out      = x_out_q;
  assign y_out      = y_out_q;
  assign colour_out = colour_out_q;
  assign plot       = plot_q;
  assign length_inc = length_inc_q;
  assign is_dead    = hit_q;

endmodule
`default_nettype wire

// File: tb/tb_snake_body_datapath.sv
`default_nettype none
// ============================================================================
// Module   : tb_snake_body_datapath
// Purpose  : Self-checking bench for snake_body_datapath: a vector table,
//            hand-written multi-cycle sequences and a randomized run checked
//            against a behavioural model of the body/head rules.
// Revision : 1.0 - initial release
// ============================================================================
module tb_snake_body_datapath;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic [1:0]  dir;
  logic [12:0] strb;
  logic [3:0]  cnt_status;
  logic [2:0]  colour_in;
  logic [7:0]  food_x;
  logic [6:0]  food_y;
  logic [7:0]  x_out;
  logic [6:0]  y_out;
  logic [2:0]  colour_out;
  logic        plot;
  logic        length_inc;
  logic        is_dead;

  localparam logic [12:0] NONE = 13'h0000;
  localparam logic [12:0] LDH  = 13'h0001;
  localparam logic [12:0] QDEF = 13'h0002;
  localparam logic [12:0] INCA = 13'h0004;
  localparam logic [12:0] RSTA = 13'h0008;
  localparam logic [12:0] UPD  = 13'h0010;
  localparam logic [12:0] HP   = 13'h0020;
  localparam logic [12:0] QC   = 13'h0040;
  localparam logic [12:0] PQ   = 13'h0080;
  localparam logic [12:0] CP   = 13'h0100;
  localparam logic [12:0] LEN  = 13'h0200;
  localparam logic [12:0] DQ   = 13'h0400;
  localparam logic [12:0] DC   = 13'h0800;
  localparam logic [12:0] FOOD = 13'h1000;

  snake_body_datapath dut (
    .clk               (clk),
    .rst               (rst),
    .dir               (dir),
    .ld_head           (strb[0]),
    .ld_q_def          (strb[1]),
    .inc_address       (strb[2]),
    .rst_address       (strb[3]),
    .update_head       (strb[4]),
    .ld_head_into_prev (strb[5]),
    .ld_q_into_curr    (strb[6]),
    .ld_prev_into_q    (strb[7]),
    .ld_curr_into_prev (strb[8]),
    .inc_length_check  (strb[9]),
    .draw_q            (strb[10]),
    .draw_curr         (strb[11]),
    .food_en           (strb[12]),
    .cnt_status        (cnt_status),
    .colour_in         (colour_in),
    .food_x            (food_x),
    .food_y            (food_y),
    .x_out             (x_out),
    .y_out             (y_out),
    .colour_out        (colour_out),
    .plot              (plot),
    .length_inc        (length_inc),
    .is_dead           (is_dead)
  );

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [12:0] s;
    logic [1:0]  d;
    logic [3:0]  c;
    logic [2:0]  col;
    logic [7:0]  fx;
    logic [6:0]  fy;
    logic        e_plot;
    logic [7:0]  e_x;
    logic [6:0]  e_y;
    logic [2:0]  e_col;
    logic        e_len;
    logic        e_dead;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(input logic [12:0] s, input logic [1:0] d, input logic [3:0] c,
                              input logic [2:0] col, input logic [7:0] fx, input logic [6:0] fy,
                              input logic ep, input logic [7:0] ex, input logic [6:0] ey,
                              input logic [2:0] ec, input logic el, input logic ed);
    vec_t v;
    v.s = s; v.d = d; v.c = c; v.col = col; v.fx = fx; v.fy = fy;
    v.e_plot = ep; v.e_x = ex; v.e_y = ey; v.e_col = ec; v.e_len = el; v.e_dead = ed;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic cycle(input logic r, input logic [12:0] s, input logic [1:0] d, input logic [3:0] c,
                       input logic [2:0] col, input logic [7:0] fx, input logic [6:0] fy);
    rst = r; strb = s; dir = d; cnt_status = c; colour_in = col; food_x = fx; food_y = fy;
    @(posedge clk);
    #1;
  endtask

  task automatic op(input logic [12:0] s);
    cycle(1'b0, s, 2'd0, 4'd0, 3'd0, 8'd0, 7'd0);
  endtask

  task automatic chk_out(input string nm, input logic ep, input logic [7:0] ex, input logic [6:0] ey,
                         input logic [2:0] ec, input logic el, input logic ed);
    chk({nm, ".plot"}, 32'(plot), 32'(ep));
    chk({nm, ".length_inc"}, 32'(length_inc), 32'(el));
    chk({nm, ".is_dead"}, 32'(is_dead), 32'(ed));
    if (ep) begin
      chk({nm, ".x"}, 32'(x_out), 32'(ex));
      chk({nm, ".y"}, 32'(y_out), 32'(ey));
      chk({nm, ".colour"}, 32'(colour_out), 32'(ec));
    end
  endtask

  // ----------------------------------------------------- behavioural model
  int m_hx, m_hy, m_hd, m_px, m_py, m_cx, m_cy, m_addr, m_hit;
  int m_mx[64];
  int m_my[64];
  logic       e_plot, e_len, e_dead;
  logic [7:0] e_x;
  logic [6:0] e_y;
  logic [2:0] e_col;

  task automatic m_step(input logic r, input logic [12:0] s, input logic [1:0] d, input logic [3:0] c,
                        input logic [2:0] col, input logic [7:0] fx, input logic [6:0] fy);
    int n_hx, n_hy, n_hd, n_px, n_py, n_cx, n_cy, n_addr, n_hit;
    int qx, qy, ox, oy, nx, ny, ci;
    bit rev;
    if (r) begin
      m_hx = 80; m_hy = 60; m_hd = 0; m_px = 0; m_py = 0; m_cx = 0; m_cy = 0;
      m_addr = 0; m_hit = 0;
      e_plot = 1'b0; e_len = 1'b0; e_dead = 1'b0;
      return;
    end
    n_hx = m_hx; n_hy = m_hy; n_hd = m_hd; n_px = m_px; n_py = m_py;
    n_cx = m_cx; n_cy = m_cy; n_addr = m_addr; n_hit = m_hit;
    qx = m_mx[m_addr]; qy = m_my[m_addr];
    ci = int'(c);

    e_plot = (s[12] || s[10] || s[11]) && (ci <= 8);
    if (e_plot) begin
      if (s[12])      begin ox = int'(fx); oy = int'(fy); e_col = 3'd2; end
      else if (s[10]) begin ox = qx; oy = qy; e_col = col; end
      else            begin ox = m_cx; oy = m_cy; e_col = 3'd0; end
      e_x = 8'((ox + ci % 3) % 256);
      e_y = 7'((oy + ci / 3) % 128);
    end
    e_len = s[9] && (m_hx == int'(fx)) && (m_hy == int'(fy));

    if (s[4]) begin
      rev = (m_hd == 0 && d == 2'd1) || (m_hd == 1 && d == 2'd0) ||
            (m_hd == 2 && d == 2'd3) || (m_hd == 3 && d == 2'd2);
      n_hd = rev ? m_hd : int'(d);
      nx = m_hx; ny = m_hy;
      case (n_hd)
        0: nx = nx + 3;
        1: nx = nx - 3;
        2: ny = ny - 3;
        default: ny = ny + 3;
      endcase
      if (nx < 0 || ny < 0 || nx > 157 || ny > 117) n_hit = 1;
      else begin n_hx = nx; n_hy = ny; end
    end
    if (s[5]) begin n_px = m_hx; n_py = m_hy; end
    if (s[8]) begin n_px = m_cx; n_py = m_cy; end
    if (s[6]) begin
      n_cx = qx; n_cy = qy;
      if (m_addr != 0 && qx == m_hx && qy == m_hy) n_hit = 1;
    end
    if (s[7]) begin
      m_mx[m_addr] = m_px; m_my[m_addr] = m_py;
    end else if (s[1]) begin
      m_mx[m_addr] = (80 - 3 * m_addr) & 255; m_my[m_addr] = 60;
    end
    if (s[3]) n_addr = 0;
    else if (s[2]) n_addr = (m_addr < 63) ? m_addr + 1 : 63;
    if (s[0]) begin n_hx = 80; n_hy = 60; n_hd = 0; n_hit = 0; end

    m_hx = n_hx; m_hy = n_hy; m_hd = n_hd; m_px = n_px; m_py = n_py;
    m_cx = n_cx; m_cy = n_cy; m_addr = n_addr; m_hit = n_hit;
    e_dead = (m_hit != 0);
  endtask

  task automatic mcycle(input logic r, input logic [12:0] s, input logic [1:0] d, input logic [3:0] c,
                        input logic [2:0] col, input logic [7:0] fx, input logic [6:0] fy);
    m_step(r, s, d, c, col, fx, fy);
    cycle(r, s, d, c, col, fx, fy);
    chk_out("rnd", e_plot, e_x, e_y, e_col, e_len, e_dead);
  endtask

  // ------------------------------------------------------------------ test
  initial begin
    logic [12:0] s;
    logic [7:0]  fx;
    logic [6:0]  fy;
    int k;

    rst = 1'b1; strb = NONE; dir = 2'd0; cnt_status = 4'd0; colour_in = 3'd0;
    food_x = 8'd0; food_y = 7'd0;

    cycle(1'b1, NONE, 2'd0, 4'd0, 3'd0, 8'd0, 7'd0);
    chk("reset.plot", 32'(plot), 32'd0);
    chk("reset.length_inc", 32'(length_inc), 32'd0);
    chk("reset.is_dead", 32'(is_dead), 32'd0);
    chk("reset.x", 32'(x_out), 32'd0);
    chk("reset.y", 32'(y_out), 32'd0);
    chk("reset.colour", 32'(colour_out), 32'd0);

    // Load default body, draw cells, move and check food.
    tbl.push_back(mk(LDH,         2'd0, 4'd0, 3'd0, 8'd0, 7'd0, 0, 8'd0, 7'd0, 3'd0, 0, 0));
    tbl.push_back(mk(QDEF,        2'd0, 4'd0, 3'd0, 8'd0, 7'd0, 0, 8'd0, 7'd0, 3'd0, 0, 0));
    tbl.push_back(mk(INCA,        2'd0, 4'd0, 3'd0, 8'd0, 7'd0, 0, 8'd0, 7'd0, 3'd0, 0, 0));
    tbl.push_back(mk(QDEF,        2'd0, 4'd0, 3'd0, 8'd0, 7'd0, 0, 8'd0, 7'd0, 3'd0, 0, 0));
    tbl.push_back(mk(INCA,        2'd0, 4'd0, 3'd0, 8'd0, 7'd0, 0, 8'd0, 7'd0, 3'd0, 0, 0));
    tbl.push_back(mk(QDEF,        2'd0, 4'd0, 3'd0, 8'd0, 7'd0, 0, 8'd0, 7'd0, 3'd0, 0, 0));
    tbl.push_back(mk(RSTA | INCA, 2'd0, 4'd0, 3'd0, 8'd0, 7'd0, 0, 8'd0, 7'd0, 3'd0, 0, 0));
    tbl.push_back(mk(DQ,          2'd0, 4'd4, 3'd5, 8'd0, 7'd0, 1, 8'd81, 7'd61, 3'd5, 0, 0));
    tbl.push_back(mk(INCA,        2'd0, 4'd0, 3'd0, 8'd0, 7'd0, 0, 8'd0, 7'd0, 3'd0, 0, 0));
    for (int i = 0; i < 9; i++)
      tbl.push_back(mk(DQ, 2'd0, 4'(i), 3'd1, 8'd0, 7'd0, 1, 8'(77 + i % 3), 7'(60 + i / 3), 3'd1, 0, 0));
    tbl.push_back(mk(DQ,          2'd0, 4'd9, 3'd1, 8'd0, 7'd0, 0, 8'd0, 7'd0, 3'd0, 0, 0));
    tbl.push_back(mk(DQ | FOOD,   2'd0, 4'd0, 3'd1, 8'd10, 7'd20, 1, 8'd10, 7'd20, 3'd2, 0, 0));
    tbl.push_back(mk(DQ | DC,     2'd0, 4'd2, 3'd6, 8'd0, 7'd0, 1, 8'd79, 7'd60, 3'd6, 0, 0));
    tbl.push_back(mk(UPD,         2'd0, 4'd0, 3'd0, 8'd0, 7'd0, 0, 8'd0, 7'd0, 3'd0, 0, 0));
    tbl.push_back(mk(LEN,         2'd0, 4'd0, 3'd0, 8'd83, 7'd60, 0, 8'd0, 7'd0, 3'd0, 1, 0));
    tbl.push_back(mk(NONE,        2'd0, 4'd0, 3'd0, 8'd83, 7'd60, 0, 8'd0, 7'd0, 3'd0, 0, 0));
    tbl.push_back(mk(UPD,         2'd1, 4'd0, 3'd0, 8'd0, 7'd0, 0, 8'd0, 7'd0, 3'd0, 0, 0));
    tbl.push_back(mk(LEN,         2'd0, 4'd0, 3'd0, 8'd90, 7'd60, 0, 8'd0, 7'd0, 3'd0, 0, 0));
    tbl.push_back(mk(LEN,         2'd0, 4'd0, 3'd0, 8'd86, 7'd60, 0, 8'd0, 7'd0, 3'd0, 1, 0));

    foreach (tbl[i]) begin
      cycle(1'b0, tbl[i].s, tbl[i].d, tbl[i].c, tbl[i].col, tbl[i].fx, tbl[i].fy);
      chk_out($sformatf("vec%0d", i), tbl[i].e_plot, tbl[i].e_x, tbl[i].e_y, tbl[i].e_col,
              tbl[i].e_len, tbl[i].e_dead);
    end

    // Right wall: 80 -> 155 in 25 steps, the next step would reach 158.
    op(LDH);
    for (int i = 0; i < 25; i++) cycle(1'b0, UPD, 2'd0, 4'd0, 3'd0, 8'd0, 7'd0);
    cycle(1'b0, LEN, 2'd0, 4'd0, 3'd0, 8'd155, 7'd60);
    chk_out("wall_pre", 0, 8'd0, 7'd0, 3'd0, 1, 0);
    cycle(1'b0, UPD, 2'd0, 4'd0, 3'd0, 8'd0, 7'd0);
    chk_out("wall_hit", 0, 8'd0, 7'd0, 3'd0, 0, 1);
    cycle(1'b0, LEN, 2'd0, 4'd0, 3'd0, 8'd155, 7'd60);
    chk_out("wall_hold", 0, 8'd0, 7'd0, 3'd0, 1, 1);
    op(LDH);
    chk_out("wall_clear", 0, 8'd0, 7'd0, 3'd0, 0, 0);

    // Top edge: y = 0 is legal, one more step up underflows.
    for (int i = 0; i < 20; i++) cycle(1'b0, UPD, 2'd2, 4'd0, 3'd0, 8'd0, 7'd0);
    cycle(1'b0, LEN, 2'd0, 4'd0, 3'd0, 8'd80, 7'd0);
    chk_out("top_edge", 0, 8'd0, 7'd0, 3'd0, 1, 0);
    cycle(1'b0, UPD, 2'd2, 4'd0, 3'd0, 8'd0, 7'd0);
    chk_out("top_hit", 0, 8'd0, 7'd0, 3'd0, 0, 1);
    op(LDH);
    chk_out("top_clear", 0, 8'd0, 7'd0, 3'd0, 0, 0);

    // Shift pass of length 3 after moving the head to (83,60).
    cycle(1'b0, UPD, 2'd0, 4'd0, 3'd0, 8'd0, 7'd0);
    op(HP);
    op(RSTA);
    for (int i = 0; i < 3; i++) begin
      op(QC);
      op(PQ);
      op(CP | INCA);
    end
    chk_out("pass_nodead", 0, 8'd0, 7'd0, 3'd0, 0, 0);
    for (int i = 0; i < 9; i++) begin
      cycle(1'b0, DC, 2'd0, 4'(i), 3'd7, 8'd0, 7'd0);
      chk_out("erase_tail", 1, 8'(74 + i % 3), 7'(60 + i / 3), 3'd0, 0, 0);
    end
    op(RSTA);
    cycle(1'b0, DQ, 2'd0, 4'd0, 3'd3, 8'd0, 7'd0);
    chk_out("pass_mem0", 1, 8'd83, 7'd60, 3'd3, 0, 0);
    op(INCA);
    cycle(1'b0, DQ, 2'd0, 4'd8, 3'd3, 8'd0, 7'd0);
    chk_out("pass_mem1", 1, 8'd82, 7'd62, 3'd3, 0, 0);
    op(INCA);
    cycle(1'b0, DQ, 2'd0, 4'd4, 3'd3, 8'd0, 7'd0);
    chk_out("pass_mem2", 1, 8'd78, 7'd61, 3'd3, 0, 0);

    // Self collision: ignored at entry 0, detected at entry 1.
    op(RSTA);
    op(QC);
    chk_out("self_addr0", 0, 8'd0, 7'd0, 3'd0, 0, 0);
    op(HP);
    op(INCA);
    op(PQ);
    cycle(1'b0, DQ, 2'd0, 4'd0, 3'd7, 8'd0, 7'd0);
    chk_out("self_mem1", 1, 8'd83, 7'd60, 3'd7, 0, 0);
    op(QC);
    chk_out("self_hit", 0, 8'd0, 7'd0, 3'd0, 0, 1);

    // Reset in the middle of activity, with a draw request present.
    cycle(1'b1, DC | LEN, 2'd0, 4'd0, 3'd0, 8'd80, 7'd60);
    chk_out("midrst", 0, 8'd0, 7'd0, 3'd0, 0, 0);
    chk("midrst.x", 32'(x_out), 32'd0);

    // Randomized run against the model; start by loading the whole memory.
    mcycle(1'b1, NONE, 2'd0, 4'd0, 3'd0, 8'd0, 7'd0);
    mcycle(1'b0, RSTA, 2'd0, 4'd0, 3'd0, 8'd0, 7'd0);
    for (int i = 0; i < 64; i++) begin
      mcycle(1'b0, QDEF, 2'd0, 4'd0, 3'd0, 8'd0, 7'd0);
      mcycle(1'b0, INCA, 2'd0, 4'd0, 3'd0, 8'd0, 7'd0);
    end
    mcycle(1'b0, INCA, 2'd0, 4'd0, 3'd0, 8'd0, 7'd0);
    mcycle(1'b0, DQ, 2'd0, 4'd0, 3'd1, 8'd0, 7'd0);
    chk("sat_addr_x", 32'(x_out), 32'd147);

    for (int n = 0; n < 2500; n++) begin
      k = $urandom_range(0, 11);
      s = NONE;
      if (k < 10) s[k] = 1'b1;
      if (s[8] && ($urandom_range(0, 1) == 1)) s[2] = 1'b1;
      if (s[3] && ($urandom_range(0, 1) == 1)) s[2] = 1'b1;
      if (s[7] && ($urandom_range(0, 2) == 0)) s[1] = 1'b1;
      s[10] = ($urandom_range(0, 2) == 0);
      s[11] = ($urandom_range(0, 2) == 0);
      s[12] = ($urandom_range(0, 4) == 0);
      if ($urandom_range(0, 1) == 1) begin
        fx = 8'(m_hx); fy = 7'(m_hy);
      end else begin
        fx = 8'($urandom); fy = 7'($urandom);
      end
      mcycle(($urandom_range(0, 99) == 0), s, 2'($urandom), 4'($urandom_range(0, 10)),
             3'($urandom), fx, fy);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
